// File: rtl/seq_detect_ctrl.sv
// Programmable serial-pattern detector: a pattern, length, hit target, overlap mode and timeout
// are loaded while IDLE, then a RUN shifts in x_i and counts matches until target, timeout or abort.
module seq_detect_ctrl #(
    parameter  int MAX_LEN = 16,
    parameter  int CNT_W   = 8,
    parameter  int TMO_W   = 16,
    localparam int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid_i,
    output logic               cfg_ready_o,
    input  logic [MAX_LEN-1:0] cfg_pattern_i,
    input  logic [LEN_W-1:0]   cfg_len_i,
    input  logic [CNT_W-1:0]   cfg_hits_i,
    input  logic               cfg_overlap_i,
    input  logic [TMO_W-1:0]   cfg_tmo_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic               x_i,
    output logic               det_o,
    output logic [CNT_W-1:0]   hit_cnt_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               timeout_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    logic [0:0]         r_state;
    logic               r_cfg_loaded;
    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic [CNT_W-1:0]   r_hits;
    logic               r_overlap;
    logic [TMO_W-1:0]   r_tmo;

    logic [MAX_LEN-1:0] r_shift;
    logic [LEN_W-1:0]   r_fill;
    logic [TMO_W-1:0]   r_timer;
    logic [CNT_W-1:0]   r_hit_cnt;
    logic               r_det;
    logic               r_done;
    logic               r_timeout;

    logic               w_cfg_ready;
    logic               w_cfg_accept;
    logic               w_start;
    logic [LEN_W-1:0]   w_len_clamped;
    logic [CNT_W-1:0]   w_hits_clamped;

    logic [MAX_LEN-1:0] w_shift_next;
    logic [LEN_W-1:0]   w_fill_next;
    logic [TMO_W-1:0]   w_timer_next;
    logic [CNT_W-1:0]   w_hit_next;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_match;
    logic               w_final;
    logic               w_tmo_expire;

    assign w_cfg_ready  = (r_state == ST_IDLE);
    assign w_cfg_accept = cfg_valid_i && w_cfg_ready;
    // A config handshake in the same cycle as start_i wins; the start is dropped.
    assign w_start      = w_cfg_ready && start_i && r_cfg_loaded && !w_cfg_accept;

    always_comb begin
        w_len_clamped = cfg_len_i;
        if (cfg_len_i == '0) begin
            w_len_clamped = LEN_W'(1);
        end else if (cfg_len_i > LEN_MAX) begin
            w_len_clamped = LEN_MAX;
        end
        w_hits_clamped = (cfg_hits_i == '0) ? CNT_W'(1) : cfg_hits_i;
    end

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (LEN_W'(i) < r_len);
        end
    end

    // Fill counts valid bits seen, so bits cleared at start or before a fresh window never match.
    always_comb begin
        w_shift_next = {r_shift[MAX_LEN-2:0], x_i};
        w_fill_next  = (r_fill >= LEN_MAX) ? r_fill : r_fill + LEN_W'(1);
        w_timer_next = r_timer + TMO_W'(1);
        w_hit_next   = r_hit_cnt + CNT_W'(1);
        w_match      = (w_fill_next >= r_len) &&
                       (((w_shift_next ^ r_pattern) & w_mask) == '0);
        w_final      = w_match && (w_hit_next == r_hits);
        w_tmo_expire = (r_tmo != '0) && (w_timer_next == r_tmo);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cfg_loaded <= 1'b0;
            r_pattern    <= '0;
            r_len        <= LEN_W'(1);
            r_hits       <= CNT_W'(1);
            r_overlap    <= 1'b0;
            r_tmo        <= '0;
        end else begin
            if (w_cfg_accept) begin
                r_cfg_loaded <= 1'b1;
                r_pattern    <= cfg_pattern_i;
                r_len        <= w_len_clamped;
                r_hits       <= w_hits_clamped;
                r_overlap    <= cfg_overlap_i;
                r_tmo        <= cfg_tmo_i;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort_i || w_final || w_tmo_expire) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Abort suppresses every effect of the sample taken on its edge, including the hit count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift   <= '0;
            r_fill    <= '0;
            r_timer   <= '0;
            r_hit_cnt <= '0;
            r_det     <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_det     <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            if (w_start) begin
                r_shift   <= '0;
                r_fill    <= '0;
                r_timer   <= '0;
                r_hit_cnt <= '0;
            end else if ((r_state == ST_RUN) && !abort_i) begin
                r_shift <= w_shift_next;
                r_timer <= w_timer_next;
                r_fill  <= (w_match && !r_overlap) ? '0 : w_fill_next;
                if (w_match) begin
                    r_det     <= 1'b1;
                    r_hit_cnt <= w_hit_next;
                end
                if (w_final) begin
                    r_done <= 1'b1;
                end else if (w_tmo_expire) begin
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    assign cfg_ready_o = w_cfg_ready;
    assign busy_o      = (r_state == ST_RUN);
    assign det_o       = r_det;
    assign done_o      = r_done;
    assign timeout_o   = r_timeout;
    assign hit_cnt_o   = r_hit_cnt;

endmodule
